bnn_act_packer: RTL and testbench
=================================

# bnn_act_packer

Receive-side companion to the XNOR convolution core: consumes the core's per-pixel `valid`/`binary_out` stream, one raster-ordered output channel at a time. It packs the thresholded activation bits into `WORD_W`-bit words and tags each word with a linear feature-map word address. Words go to the activation buffer writer over a valid/ready interface. The core has no backpressure, so the packer buffers words and flags any loss with a sticky overflow bit.

## Interface
- `WORD_W`, 32, bits per packed word; power of two, 8..64.
- `FMAP_W`, 32, pixels per feature-map row.
- `FMAP_H`, 32, rows per feature map.
- `N_CH`, 64, output channels per layer pass.
- `ADDR_W`, derived: $clog2(N_CH*ceil(FMAP_W*FMAP_H/WORD_W)).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; arms a layer pass of `N_CH` channels.
- `in_valid`  in  1  activation bit valid (core `valid`).
- `in_bit`  in  1  activation bit (core `binary_out`).
- `m_valid`  out  1  packed word available.
- `m_ready`  in  1  downstream accepts word.
- `m_data`  out  WORD_W  packed bits; first pixel in bit 0.
- `m_addr`  out  ADDR_W  word address = ch * WPC + word index, where WPC = ceil(FMAP_W*FMAP_H/WORD_W).
- `m_last`  out  1  marks the final word of a channel.
- `busy`  out  1  pass in progress.
- `done`  out  1  one-cycle pulse when the final word of channel `N_CH-1` is accepted.
- `overflow`  out  1  sticky; a word was dropped. Cleared only by `rst` or `start`.

## Operation
- States: IDLE, PACK, DRAIN.
  - IDLE: `busy`=0. `start` clears counters and `overflow`, then moves to PACK. `in_valid` is ignored in IDLE.
  - PACK: each `in_valid` shifts `in_bit` into the shift register at position `bit_cnt` and increments `pix_cnt`. When `bit_cnt` reaches `WORD_W-1` or the last pixel of the channel arrives (`pix_cnt` = FMAP_W*FMAP_H-1), the word is pushed to the output FIFO.
    - Unfilled upper bits of a partial final word are zero.
    - After the last pixel, `pix_cnt` and `bit_cnt` reset and `ch_cnt` increments.
    - After the last pixel of channel `N_CH-1`, move to DRAIN.
  - DRAIN: wait until the FIFO is empty and the last word is accepted, pulse `done`, then return to IDLE. `in_valid` is ignored in DRAIN.
- Output FIFO: 2 entries, each holding {data, addr, last}. Push and pop may happen in the same cycle, including when the FIFO is full.
- Push into a full FIFO with no simultaneous pop:
  - the new word is dropped and `overflow` is set;
  - counters still advance, so addresses stay aligned.
- `start` while `busy` is ignored.
- `m_data`, `m_addr` and `m_last` hold stable while `m_valid`=1 and `m_ready`=0.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_addr`=0, `m_last`=0, `busy`=0, `done`=0, `overflow`=0. All counters 0; state IDLE.
- `busy` goes high the cycle after `start`.
- Word latency: the completing bit is sampled on edge N, and `m_valid` rises after edge N (cycle N+1) when the FIFO was empty.
- Throughput: one bit per cycle sustained. A word leaves at most every `WORD_W` cycles, so with `m_ready` held high the FIFO never overflows.
- `done` is high for exactly one cycle: the cycle after the final handshake. `busy` falls in that same cycle.
- `rst` mid-pass discards FIFO contents and partial words; no `done` is produced.

## Structure
- Shared `bnn_pkg` holds: state enum (IDLE/PACK/DRAIN), `WORD_W` default, and the WPC/`ADDR_W` computation function. These are reused by the activation buffer writer.
- One sub-module, `act_word_fifo`: 2-entry synchronous FIFO with full/empty flags and simultaneous push/pop. It is parameterised on payload width.
- Top level holds the FSM, the shift register and the `bit_cnt`/`pix_cnt`/`ch_cnt` counters.

## Test plan
Unless stated, parameters are WORD_W=8, FMAP_W=4, FMAP_H=4, N_CH=2, giving WPC=2.

- **Basic pass:** `start`, then 32 bits alternating 1,0 with `m_ready`=1. Expect 4 words of 0x55 at addresses 0,1,2,3, with `m_last` on addresses 1 and 3, and `done` one cycle after the 4th handshake.
- **Partial word** (FMAP_W=3, FMAP_H=3, N_CH=1): 9 ones. Expect words 0xFF@0 and 0x01@1 with `m_last`=1, then `done`.
- **Backpressure hold and overflow:** hold `m_ready`=0 through 24 bits.
  - The first word's payload holds stable across the stall.
  - The 3rd word is dropped and `overflow`=1.
  - After releasing `m_ready`, addresses 0 and 1 drain, then the 4th word appears at address 3.
- **Simultaneous push/pop on full FIFO:** no drop; `overflow` stays 0.
- **`start` while busy:** ignored. **`in_valid` in IDLE:** no `m_valid`.
- **Reset mid-pass:** assert `rst` after 12 bits. Expect all outputs at reset values next cycle; a fresh `start` produces addresses starting from 0.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN activation path: packer FSM states,
// default word width and feature-map word addressing helpers.
package bnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_DRAIN = 2'd2
    } pack_state_e;

    localparam int WORD_W_DEFAULT = 32;

    // Counter width for a count of n values, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packed words per channel: ceil(pixels / word width).
    function automatic int calc_wpc(input int fmap_w, input int fmap_h, input int word_w);
        return (fmap_w * fmap_h + word_w - 1) / word_w;
    endfunction

    // Address width covering every word of every channel in one pass.
    function automatic int calc_addr_w(input int fmap_w, input int fmap_h,
                                       input int word_w, input int n_ch);
        return cnt_w(n_ch * calc_wpc(fmap_w, fmap_h, word_w));
    endfunction

endpackage

// File: rtl/act_word_fifo.sv
// Two-entry synchronous FIFO for packed activation words. A push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle;
// otherwise it is dropped and reported on drop.
module act_word_fifo #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [PAYLOAD_W-1:0] push_data,
    input  logic                 pop,
    output logic [PAYLOAD_W-1:0] head_data,
    output logic                 full,
    output logic                 empty,
    output logic                 drop
);

    logic [PAYLOAD_W-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic                 do_push;
    logic                 do_pop;

    assign empty     = (count == 2'd0);
    assign full      = (count == 2'd2);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign drop      = push && !do_push;
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Entry storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/bnn_act_packer.sv
// Packs the XNOR core's per-pixel activation bits into WORD_W-bit words,
// tags them with a linear feature-map word address and queues them for
// the activation buffer writer. Words lost to a full queue set a sticky
// overflow flag; counters keep advancing so later addresses stay correct.
module bnn_act_packer
    import bnn_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT,
    parameter int FMAP_W = 32,
    parameter int FMAP_H = 32,
    parameter int N_CH   = 64,
    parameter int ADDR_W = calc_addr_w(FMAP_W, FMAP_H, WORD_W, N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int NPIX  = FMAP_W * FMAP_H;
    localparam int BIT_W = $clog2(WORD_W);
    localparam int PIX_W = cnt_w(NPIX);
    localparam int CH_W  = cnt_w(N_CH);
    localparam int PLD_W = WORD_W + ADDR_W + 1;

    pack_state_e       state;
    pack_state_e       state_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [PIX_W-1:0]  pix_cnt;
    logic [CH_W-1:0]   ch_cnt;
    logic [ADDR_W-1:0] word_addr;
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] push_word;
    logic              clear;
    logic              accept;
    logic              done_nxt;
    logic              last_pix;
    logic              last_ch;
    logic              word_full;
    logic              push;
    logic [PLD_W-1:0]  push_pld;
    logic [PLD_W-1:0]  head_pld;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;

    assign last_pix  = (pix_cnt == PIX_W'(NPIX - 1));
    assign last_ch   = (ch_cnt == CH_W'(N_CH - 1));
    assign word_full = (bit_cnt == BIT_W'(WORD_W - 1));
    assign push      = accept && (word_full || last_pix);
    // Bits at and above bit_cnt are still zero, so a partial word has zero upper bits.
    assign push_word = sreg | (WORD_W'(in_bit) << bit_cnt);
    assign push_pld  = {push_word, word_addr, last_pix};

    act_word_fifo #(
        .PAYLOAD_W(PLD_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_pld),
        .pop      (m_ready),
        .head_data(head_pld),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );

    assign m_valid = !fifo_empty;
    assign {m_data, m_addr, m_last} = head_pld;
    assign busy    = (state != ST_IDLE);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        accept    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = ST_PACK;
                end
            end
            ST_PACK: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (last_pix && last_ch) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish once the single remaining word is taken (or nothing is left).
                if (fifo_empty || (!fifo_full && m_ready)) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bit, pixel, channel and word-address counters.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bit_cnt   <= '0;
            pix_cnt   <= '0;
            ch_cnt    <= '0;
            word_addr <= '0;
        end else if (accept) begin
            bit_cnt <= push ? '0 : bit_cnt + BIT_W'(1);
            if (push) word_addr <= word_addr + ADDR_W'(1);
            if (last_pix) begin
                pix_cnt <= '0;
                ch_cnt  <= last_ch ? '0 : ch_cnt + CH_W'(1);
            end else begin
                pix_cnt <= pix_cnt + PIX_W'(1);
            end
        end
    end

    // Shift register collecting the word under construction.
    always_ff @(posedge clk) begin
        if (clear || push) sreg <= '0;
        else if (accept)   sreg <= push_word;
    end

    // Sticky overflow flag and registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= done_nxt;
            if (clear)          overflow <= 1'b0;
            else if (fifo_drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bnn_act_packer.sv
// Directed bench for bnn_act_packer: a WORD_W=8 4x4x2 instance and a
// 3x3x1 instance for the partial final word.
module tb_bnn_act_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, in_valid, in_bit, m_ready;
    logic       m_valid, m_last, busy, done, overflow;
    logic [7:0] m_data;
    logic [1:0] m_addr;

    logic       p_start, p_in_valid, p_in_bit, p_m_ready;
    logic       p_m_valid, p_m_last, p_busy, p_done, p_overflow;
    logic [7:0] p_m_data;
    logic [0:0] p_m_addr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] hs_d[$];
    int         hs_a[$];
    logic       hs_l[$];
    int         hs_c[$];
    int         done_c[$];
    logic [7:0] p_hs_d[$];
    int         p_hs_a[$];
    logic       p_hs_l[$];
    int         p_done_n = 0;
    logic [7:0] wv [4];

    always #5 clk = ~clk;

    bnn_act_packer #(.WORD_W(8), .FMAP_W(4), .FMAP_H(4), .N_CH(2)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_bit(in_bit),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr),
        .m_last(m_last), .busy(busy), .done(done), .overflow(overflow)
    );

    bnn_act_packer #(.WORD_W(8), .FMAP_W(3), .FMAP_H(3), .N_CH(1)) dut_p (
        .clk(clk), .rst(rst), .start(p_start), .in_valid(p_in_valid), .in_bit(p_in_bit),
        .m_valid(p_m_valid), .m_ready(p_m_ready), .m_data(p_m_data), .m_addr(p_m_addr),
        .m_last(p_m_last), .busy(p_busy), .done(p_done), .overflow(p_overflow)
    );

    // Handshake and done monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_valid && m_ready) begin
            hs_d.push_back(m_data);
            hs_a.push_back(int'(m_addr));
            hs_l.push_back(m_last);
            hs_c.push_back(cyc);
        end
        if (done) done_c.push_back(cyc);
        if (p_m_valid && p_m_ready) begin
            p_hs_d.push_back(p_m_data);
            p_hs_a.push_back(int'(p_m_addr));
            p_hs_l.push_back(p_m_last);
        end
        if (p_done) p_done_n++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        hs_d.delete(); hs_a.delete(); hs_l.delete(); hs_c.delete(); done_c.delete();
    endtask

    task automatic check_hs(input string tag, input int idx, input logic [7:0] d,
                            input int a, input logic l);
        if (idx < hs_d.size()) begin
            check($sformatf("%s_data%0d", tag, idx), 32'(hs_d[idx]), 32'(d));
            check($sformatf("%s_addr%0d", tag, idx), hs_a[idx], a);
            check($sformatf("%s_last%0d", tag, idx), 32'(hs_l[idx]), 32'(l));
        end else begin
            check($sformatf("%s_missing%0d", tag, idx), hs_d.size(), idx + 1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_done_count"}, done_c.size(), 1);
        if (done_c.size() > 0 && hs_c.size() > 0)
            check({tag, "_done_timing"}, done_c[0], hs_c[hs_c.size()-1] + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_m_addr"}, 32'(m_addr), 32'd0);
        check({tag, "_m_last"}, 32'(m_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        wv[0] = 8'h3C; wv[1] = 8'hA5; wv[2] = 8'h0F; wv[3] = 8'hC3;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; m_ready = 1'b0;
        p_start = 1'b0; p_in_valid = 1'b0; p_in_bit = 1'b0; p_m_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // in_valid while idle is ignored
        in_valid = 1'b1; in_bit = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        check("idle_m_valid", 32'(m_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic pass: alternating bits, start mid-pass ignored
        clear_q();
        m_ready = 1'b1;
        pulse_start();
        check("basic_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 32; i++) begin
            start = (i == 10);
            send_bit((i % 2) == 0);
            if (i == 6) check("basic_pre_valid", 32'(m_valid), 32'd0);
            if (i == 7) begin
                check("basic_lat_valid", 32'(m_valid), 32'd1);
                check("basic_lat_data", 32'(m_data), 32'h55);
                check("basic_lat_addr", 32'(m_addr), 32'd0);
            end
        end
        start = 1'b0;
        wait_done("basic");
        check("basic_count", hs_d.size(), 4);
        for (int j = 0; j < 4; j++) check_hs("basic", j, 8'h55, j, (j % 2) == 1);
        check("basic_ovf", 32'(overflow), 32'd0);

        // Partial final word on the 3x3x1 instance
        p_m_ready = 1'b1;
        p_start = 1'b1; tick(); p_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            p_in_valid = 1'b1; p_in_bit = 1'b1;
            tick();
        end
        p_in_valid = 1'b0;
        for (int k = 0; k < 20 && p_done_n == 0; k++) tick();
        check("part_done", p_done_n, 1);
        check("part_count", p_hs_d.size(), 2);
        if (p_hs_d.size() == 2) begin
            check("part_data0", 32'(p_hs_d[0]), 32'hFF);
            check("part_addr0", p_hs_a[0], 0);
            check("part_last0", 32'(p_hs_l[0]), 32'd0);
            check("part_data1", 32'(p_hs_d[1]), 32'h01);
            check("part_addr1", p_hs_a[1], 1);
            check("part_last1", 32'(p_hs_l[1]), 32'd1);
        end

        // Backpressure: hold, drop the third word, then drain
        clear_q();
        m_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            if (i == 24) m_ready = 1'b1;
            send_bit(wv[i/8][i%8]);
            if (i == 7) begin
                check("bp_valid", 32'(m_valid), 32'd1);
                check("bp_data_first", 32'(m_data), 32'h3C);
            end
            if (i == 15) begin
                check("bp_data_hold", 32'(m_data), 32'h3C);
                check("bp_addr_hold", 32'(m_addr), 32'd0);
                check("bp_ovf_before", 32'(overflow), 32'd0);
            end
            if (i == 23) begin
                check("bp_ovf_set", 32'(overflow), 32'd1);
                check("bp_data_after_drop", 32'(m_data), 32'h3C);
            end
        end
        wait_done("bp");
        check("bp_count", hs_d.size(), 3);
        check_hs("bp", 0, 8'h3C, 0, 1'b0);
        check_hs("bp", 1, 8'hA5, 1, 1'b1);
        check_hs("bp", 2, 8'hC3, 3, 1'b1);
        check("bp_ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous push and pop on a full FIFO
        clear_q();
        m_ready = 1'b0;
        pulse_start();
        check("sim_ovf_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 32; i++) begin
            if (i == 23) m_ready = 1'b1;
            send_bit(wv[i/8][i%8]);
            if (i == 23) begin
                check("sim_ovf", 32'(overflow), 32'd0);
                check("sim_head_data", 32'(m_data), 32'hA5);
                check("sim_head_addr", 32'(m_addr), 32'd1);
            end
        end
        wait_done("sim");
        check("sim_count", hs_d.size(), 4);
        for (int j = 0; j < 4; j++) check_hs("sim", j, wv[j], j, (j % 2) == 1);
        check("sim_ovf_end", 32'(overflow), 32'd0);

        // Reset mid-pass, then a fresh pass from address 0
        clear_q();
        m_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 12; i++) send_bit(wv[i/8][i%8]);
        check("rst_pre_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        tick();
        check("midrst_no_done", done_c.size(), 0);
        check("midrst_no_hs", hs_d.size(), 0);
        m_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 32; i++) send_bit(wv[i/8][i%8]);
        wait_done("rst2");
        check("rst2_count", hs_d.size(), 4);
        for (int j = 0; j < 4; j++) check_hs("rst2", j, wv[j], j, (j % 2) == 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
